// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates the row drive, debounces a single-column hit,
// emits one key_valid pulse per qualified press and tracks hold/release of that key.
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_onehot,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_e;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_CYCLES - 1);
  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  sync1_q, sync2_q;
  logic [3:0]  col_s;
  logic [1:0]  row_q, row_d;
  logic [1:0]  col_q, col_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        sample_onehot;
  logic [1:0]  sample_col;
  logic [3:0]  col_mask;

  function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Columns are active-low on the pins; everything downstream works active-high.
  assign col_s         = ~sync2_q;
  assign col_mask      = 4'b0001 << col_q;
  assign sample_onehot = (col_s != 4'd0) && ((col_s & (col_s - 4'd1)) == 4'd0);

  always_comb begin
    sample_col = 2'd0;
    case (col_s)
      4'b0010: sample_col = 2'd1;
      4'b0100: sample_col = 2'd2;
      4'b1000: sample_col = 2'd3;
      default: sample_col = 2'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      state_q     <= SCAN;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      cnt_q       <= 16'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      sync1_q     <= col_n;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q + 16'd1;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = 16'd0;
          if (sample_onehot) begin
            col_d   = sample_col;
            state_d = DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (col_s == col_mask) begin
          if (cnt_q == DEB_LAST) begin
            state_d     = HELD;
            cnt_d       = 16'd0;
            key_valid_d = 1'b1;
            key_code_d  = decode_key(row_q, col_q);
          end
        end else begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          cnt_d   = 16'd0;
        end
      end
      HELD: begin
        // Only the latched column matters here; other columns are ignored.
        cnt_d = 16'd0;
        if (!col_s[col_q]) state_d = RELEASE;
      end
      RELEASE: begin
        if (col_s[col_q]) begin
          state_d = HELD;
          cnt_d   = 16'd0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_comb begin
    row_onehot = 4'b0001 << row_q;
    key_held   = (state_q == HELD) || (state_q == RELEASE);
    key_valid  = key_valid_q;
    key_code   = key_code_q;
  end

endmodule
